// File: rtl/reg_writeback_ctrl_if.sv
// Bus bundle between the pipeline and the register-file write-back controller.
// The controller takes the slave view; the pipeline/testbench side takes master.
interface reg_writeback_ctrl_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  // single-cycle EX result path
  logic          ex_valid_i;
  logic [AW-1:0] ex_addr_i;
  logic [DW-1:0] ex_data_i;
  logic          ex_jr_i;
  logic          ex_sll_i;
  logic          ex_ready_o;

  // multi-cycle unit issue / completion
  logic          mc_issue_i;
  logic [AW-1:0] mc_addr_i;
  logic          mc_issue_rdy_o;
  logic          mc_done_i;
  logic [DW-1:0] mc_data_i;
  logic          mc_done_rdy_o;

  // register file write port and status
  logic               RegWrite_o;
  logic [AW-1:0]      RDaddr_o;
  logic [DW-1:0]      RDdata_o;
  logic               Jr_o;
  logic               Sll_o;
  logic [(1<<AW)-1:0] busy_o;
  logic               zero_err_o;
  logic               proto_err_o;

  modport slave (
    input  ex_valid_i, ex_addr_i, ex_data_i, ex_jr_i, ex_sll_i,
    input  mc_issue_i, mc_addr_i, mc_done_i, mc_data_i,
    output ex_ready_o, mc_issue_rdy_o, mc_done_rdy_o,
    output RegWrite_o, RDaddr_o, RDdata_o, Jr_o, Sll_o,
    output busy_o, zero_err_o, proto_err_o
  );

  modport master (
    output ex_valid_i, ex_addr_i, ex_data_i, ex_jr_i, ex_sll_i,
    output mc_issue_i, mc_addr_i, mc_done_i, mc_data_i,
    input  ex_ready_o, mc_issue_rdy_o, mc_done_rdy_o,
    input  RegWrite_o, RDaddr_o, RDdata_o, Jr_o, Sll_o,
    input  busy_o, zero_err_o, proto_err_o
  );
endinterface

// File: rtl/reg_writeback_ctrl.sv
// Register-file write-back controller. Merges the single-cycle EX path and an
// in-order multi-cycle unit onto one registered write port. Multi-cycle
// destinations are remembered in a tag FIFO and a busy scoreboard; an EX result
// colliding with a multi-cycle completion is parked in a one-entry skid register.
module reg_writeback_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input logic                clk_i,
  input logic                rst_i,
  reg_writeback_ctrl_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int NR = 1 << AW;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t state, state_next;

  // tag FIFO
  logic [AW-1:0] tags [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  logic          empty, full;

  // scoreboard
  logic [NR-1:0] busy, busy_next;

  // skid register for the EX result that lost the collision
  logic [AW-1:0] skid_addr;
  logic [DW-1:0] skid_data;
  logic          skid_jr, skid_sll;

  // write slot selected for the next cycle
  logic          emit_valid, emit_ex, emit_jr, emit_sll, capture_skid;
  logic [AW-1:0] emit_addr;
  logic [DW-1:0] emit_data;

  // handshake events
  logic          idle, done_hit, pop, orphan, issue_free, issue_ok, push;
  logic          emit_zero;

  // registered port
  logic          write_q, jr_q, sll_q, zero_err_q, proto_err_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;

  assign idle       = (state == IDLE);
  assign empty      = (count == '0);
  assign full       = (count == (PW+1)'(DEPTH));
  assign done_hit   = bus.mc_done_i && idle;
  assign pop        = done_hit && !empty;
  assign orphan     = done_hit && empty;
  assign issue_free = (bus.mc_addr_i == '0) || !busy[bus.mc_addr_i];
  assign issue_ok   = (!full || pop) && issue_free;
  assign push       = bus.mc_issue_i && issue_ok;
  assign emit_zero  = (emit_addr == '0);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: a collision parks EX in the skid and spends one cycle draining it
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (pop && bus.ex_valid_i) state_next = HOLD;
      HOLD: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: ready signals and the source of the next write slot
  always_comb begin
    bus.ex_ready_o     = 1'b0;
    bus.mc_done_rdy_o  = 1'b0;
    bus.mc_issue_rdy_o = issue_ok;
    emit_valid         = 1'b0;
    emit_ex            = 1'b0;
    emit_addr          = '0;
    emit_data          = '0;
    emit_jr            = 1'b0;
    emit_sll           = 1'b0;
    capture_skid       = 1'b0;
    case (state)
      IDLE: begin
        bus.ex_ready_o    = 1'b1;
        bus.mc_done_rdy_o = 1'b1;
        if (pop) begin
          emit_valid   = 1'b1;
          emit_addr    = tags[rd_ptr];
          emit_data    = bus.mc_data_i;
          capture_skid = bus.ex_valid_i;
        end else if (bus.ex_valid_i) begin
          emit_valid = 1'b1;
          emit_ex    = 1'b1;
          emit_addr  = bus.ex_addr_i;
          emit_data  = bus.ex_data_i;
          emit_jr    = bus.ex_jr_i;
          emit_sll   = bus.ex_sll_i;
        end
      end
      HOLD: begin
        emit_valid = 1'b1;
        emit_ex    = 1'b1;
        emit_addr  = skid_addr;
        emit_data  = skid_data;
        emit_jr    = skid_jr;
        emit_sll   = skid_sll;
      end
      default: ;
    endcase
  end

  // Tag storage needs no reset: entries are only read between push and pop
  always_ff @(posedge clk_i) begin
    if (push) tags[wr_ptr] <= bus.mc_addr_i;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // Scoreboard update: clear the retiring tag first so a same-cycle set wins
  always_comb begin
    busy_next = busy;
    if (pop) busy_next[tags[rd_ptr]] = 1'b0;
    if (push && bus.mc_addr_i != '0) busy_next[bus.mc_addr_i] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) busy <= '0;
    else       busy <= busy_next;
  end

  assign bus.busy_o = busy;

  // Skid capture of the EX result that collided with a multi-cycle completion
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      skid_addr <= '0;
      skid_data <= '0;
      skid_jr   <= 1'b0;
      skid_sll  <= 1'b0;
    end else if (capture_skid) begin
      skid_addr <= bus.ex_addr_i;
      skid_data <= bus.ex_data_i;
      skid_jr   <= bus.ex_jr_i;
      skid_sll  <= bus.ex_sll_i;
    end
  end

  // Registered write port; $zero slots are suppressed and possibly flagged
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      write_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      jr_q        <= 1'b0;
      sll_q       <= 1'b0;
      zero_err_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      write_q    <= emit_valid && !emit_zero;
      jr_q       <= emit_valid && !emit_zero && emit_jr;
      sll_q      <= emit_valid && !emit_zero && emit_sll;
      zero_err_q <= emit_valid && emit_zero && !(emit_ex && (emit_jr || emit_sll));
      if (emit_valid && !emit_zero) begin
        addr_q <= emit_addr;
        data_q <= emit_data;
      end
      if (orphan) proto_err_q <= 1'b1;
    end
  end

  assign bus.RegWrite_o  = write_q;
  assign bus.RDaddr_o    = addr_q;
  assign bus.RDdata_o    = data_q;
  assign bus.Jr_o        = jr_q;
  assign bus.Sll_o       = sll_q;
  assign bus.zero_err_o  = zero_err_q;
  assign bus.proto_err_o = proto_err_q;

endmodule
